msg_send_arbiter: RTL and testbench
===================================

Name: msg_send_arbiter

Overview:
- Shares one PipeInLast message-send sink (the DPI send path) among NUM_REQ independent requesters.
- Round-robin arbitration at message granularity: once a requester's first beat is accepted, it owns the sink until its beat with last=1 is accepted.
- Zero-latency combinational datapath mux, with registered ownership/priority state.

Parameters:
- NUM_REQ, 4, number of requester ports (2..16).
- WIDTH, 32, payload width of enq_v.
- IDX_W, $clog2(NUM_REQ), owner index width (derived; do not override).

Ports:
- CLK  input  1  clock.
- nRST  input  1  reset; synchronous, active-high.
- req_pend  input  NUM_REQ  requester i has a message waiting; held high until its first beat is accepted.
- req_enq__ENA  input  NUM_REQ  beat strobe per requester; legal only while matching RDY=1.
- req_enq_v  input  NUM_REQ*WIDTH  payload; slice i is [i*WIDTH +: WIDTH].
- req_enq_last  input  NUM_REQ  last-beat flag per requester.
- req_enq__RDY  output  NUM_REQ  one-hot-or-zero ready per requester.
- out_enq__ENA  output  1  beat strobe to sink.
- out_enq_v  output  WIDTH  payload to sink.
- out_enq_last  output  1  last flag to sink.
- out_enq__RDY  input  1  sink ready.
- busy  output  1  a multi-beat message is in progress.
- owner  output  IDX_W  index of current/last granted requester.

Behaviour:
- Reset is nRST=1 sampled at posedge CLK. It forces state=IDLE, rr_ptr=0, owner=0 and busy=0. While nRST=1, all req_enq__RDY=0 and out_enq__ENA=0.
- States: IDLE and LOCKED.
- IDLE grant selection:
  - cand = first i with req_pend[i]=1, searching from rr_ptr upward with wrap.
  - req_enq__RDY[cand] = out_enq__RDY; all others 0.
  - If no req_pend is set, all RDY=0.
- LOCKED grant: req_enq__RDY[owner] = out_enq__RDY; all others 0.
- acc = req_enq__ENA & req_enq__RDY. Any ENA without RDY is a protocol violation: it is masked and has no effect.
- out_enq__ENA = |acc. out_enq_v and out_enq_last are the slices of the granted index; they are 0 when nothing is granted.
- Latency: 0 cycles, input beat to sink, same cycle.
- Transitions on an accepted beat from index g:
  - IDLE, last=0: go to LOCKED; owner<=g.
  - IDLE, last=1 (single-beat message): stay IDLE; owner<=g; rr_ptr<=(g+1) mod NUM_REQ.
  - LOCKED, last=1: go to IDLE; rr_ptr<=(owner+1) mod NUM_REQ.
  - LOCKED, last=0: stay LOCKED.
- Wrap: the rr_ptr increment wraps at NUM_REQ, including non-power-of-two values.
- busy = (state==LOCKED).
- out_enq__RDY low mid-message: the owner is stalled and the lock is held indefinitely; there is no timeout.
- req_pend dropping while a candidate in IDLE: the grant moves to the next pending requester in the same cycle. There is no penalty.
- req_pend of the owner is ignored while LOCKED.
- Reset while LOCKED: the message is abandoned and the next cycle starts in IDLE with rr_ptr=0.

Optional Feature:
- Macro MSG_SEND_ARB_STATS_EN.
- When defined, adds the following output ports:
  - msg_count, NUM_REQ*16 bits: per-requester count of accepted last beats.
  - beat_count, 32 bits: total accepted beats.
- Both counters reset to 0 and wrap modulo 2^16 / 2^32 without saturation.
- When not defined, these ports and their registers do not exist. Arbitration behaviour is identical either way.

Decomposition:
- Package msg_send_arb_pkg holds:
  - the state enum (ARB_IDLE, ARB_LOCKED);
  - STAT_MSG_W=16 and STAT_BEAT_W=32;
  - a function next_idx(idx, n) implementing wrapped increment.
- One sub-module, msg_arb_rr_pick:
  - Combinational round-robin picker.
  - Inputs: req vector and rr_ptr. Outputs: found flag and index.
  - The parent instantiates it once.

Test Plan:
- Reset: hold nRST=1 for 3 cycles with req_pend=4'b1111 -> all RDY=0, out_enq__ENA=0, owner=0, busy=0.
- Single-beat fairness: all 4 requesters send last=1 beats continuously with out_RDY=1 -> grants go 0,1,2,3,0,1…, one per cycle. With STATS_EN, after 8 cycles each msg_count=2 and beat_count=8.
- Message atomicity: req0 sends 3 beats (0xA0, 0xA1, 0xA2 last) while req1 is pending -> out_v sequence is A0, A1, A2 with busy=1 for 2 cycles and req1 RDY=0 throughout. Req1 is granted on the next cycle.
- Backpressure: out_RDY=0 for 5 cycles mid-message of req2 -> all RDY=0, out_ENA=0, owner=2 and busy=1 are held. On resume the remaining beats complete in order.
- Wrap with NUM_REQ=3: rr_ptr=2, req_pend=3'b011 -> grant goes to 0, then 1.
- Protocol violation and reset mid-message: req3 asserts ENA while its RDY=0 -> out_ENA=0 and there is no state change. Assert nRST while LOCKED on owner 1 -> the next cycle is IDLE and, with req_pend=4'b1111, grants 0 first.

Source files
------------

// File: rtl/msg_send_arb_pkg.sv
// Shared types and helpers for the message-send arbiter.
// Covers the state encoding, the stats counter widths and the wrapped index increment.
package msg_send_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam int STAT_MSG_W  = 16;
    localparam int STAT_BEAT_W = 32;

    // Increment that wraps at n, so non-power-of-two requester counts stay in range.
    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/msg_arb_rr_pick.sv
// Combinational round-robin picker.
// Returns the first set request at or after ptr_i, wrapping around.
module msg_arb_rr_pick
    import msg_send_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        int   j;
        logic hit;
        hit   = 1'b0;
        idx_o = '0;
        j     = int'(ptr_i);
        for (int k = 0; k < N; k++) begin
            if (!hit && req_i[j]) begin
                hit   = 1'b1;
                idx_o = IDX_W'(j);
            end
            j = next_idx(j, N);
        end
        found_o = hit;
    end

endmodule

// File: rtl/msg_send_arbiter.sv
// Round-robin arbiter sharing one message-send sink among NUM_REQ requesters, message-atomic.
// Optional per-requester message and total beat counters under MSG_SEND_ARB_STATS_EN.
module msg_send_arbiter
    import msg_send_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [NUM_REQ-1:0]       req_pend,
    input  logic [NUM_REQ-1:0]       req_enq__ENA,
    input  logic [NUM_REQ*WIDTH-1:0] req_enq_v,
    input  logic [NUM_REQ-1:0]       req_enq_last,
    output logic [NUM_REQ-1:0]       req_enq__RDY,
    output logic                     out_enq__ENA,
    output logic [WIDTH-1:0]         out_enq_v,
    output logic                     out_enq_last,
    input  logic                     out_enq__RDY,
    output logic                     busy,
    output logic [IDX_W-1:0]         owner
`ifdef MSG_SEND_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_MSG_W-1:0] msg_count,
    output logic [STAT_BEAT_W-1:0]        beat_count
`endif
);

    // Handshake: a beat moves when ENA and RDY are both high in the same cycle.
    // RDY never depends on ENA, and an ENA seen while RDY is low is ignored.

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               cand_found;
    logic [IDX_W-1:0]   cand_idx;
    logic               grant_vld;
    logic [IDX_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] acc;

    msg_arb_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (req_pend),
        .ptr_i   (rr_ptr_q),
        .found_o (cand_found),
        .idx_o   (cand_idx)
    );

    // nRST is active-high: nothing is granted while it is asserted.
    always_comb begin
        grant_vld    = 1'b0;
        grant_idx    = owner_q;
        req_enq__RDY = '0;
        out_enq_v    = '0;
        out_enq_last = 1'b0;
        if (!nRST) begin
            if (state_q == ARB_LOCKED) begin
                grant_vld = 1'b1;
            end else if (cand_found) begin
                grant_vld = 1'b1;
                grant_idx = cand_idx;
            end
        end
        if (grant_vld) begin
            req_enq__RDY[grant_idx] = out_enq__RDY;
            out_enq_v               = req_enq_v[int'(grant_idx)*WIDTH +: WIDTH];
            out_enq_last            = req_enq_last[grant_idx];
        end
        acc          = req_enq__ENA & req_enq__RDY;
        out_enq__ENA = |acc;
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        if (out_enq__ENA) begin
            case (state_q)
                ARB_IDLE: begin
                    owner_d = grant_idx;
                    if (out_enq_last)
                        rr_ptr_d = IDX_W'(next_idx(int'(grant_idx), NUM_REQ));
                    else
                        state_d = ARB_LOCKED;
                end
                ARB_LOCKED: begin
                    if (out_enq_last) begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = IDX_W'(next_idx(int'(owner_q), NUM_REQ));
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign busy  = (state_q == ARB_LOCKED);
    assign owner = owner_q;

`ifdef MSG_SEND_ARB_STATS_EN
    logic [NUM_REQ*STAT_MSG_W-1:0] msg_cnt_q;
    logic [STAT_BEAT_W-1:0]        beat_cnt_q;

    // Both counters wrap freely.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            msg_cnt_q  <= '0;
            beat_cnt_q <= '0;
        end else if (out_enq__ENA) begin
            beat_cnt_q <= beat_cnt_q + STAT_BEAT_W'(1);
            if (out_enq_last)
                msg_cnt_q[int'(grant_idx)*STAT_MSG_W +: STAT_MSG_W] <=
                    msg_cnt_q[int'(grant_idx)*STAT_MSG_W +: STAT_MSG_W] + STAT_MSG_W'(1);
        end
    end

    assign msg_count  = msg_cnt_q;
    assign beat_count = beat_cnt_q;
`else
    // Default build carries no statistics state.
`endif

endmodule

// File: tb/tb_msg_send_arbiter.sv
// Self-checking bench for msg_send_arbiter: vector table plus hand-written message sequences.
// Stats ports are checked only when MSG_SEND_ARB_STATS_EN is defined.
module tb_msg_send_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  pend, ena, last;
    logic [31:0] data [4];
    logic [127:0] vbus;
    logic [3:0]  rdy;
    logic        out_ena, out_last, out_rdy, busy;
    logic [31:0] out_v;
    logic [1:0]  owner;

    logic [2:0]  p3, e3, l3, rdy3;
    logic        ena3_o, last3_o, busy3;
    logic [31:0] v3_o;
    logic [95:0] v3_bus;
    logic [1:0]  owner3;

`ifdef MSG_SEND_ARB_STATS_EN
    logic [63:0] msg_cnt;
    logic [31:0] beat_cnt;
    logic [47:0] msg_cnt3;
    logic [31:0] beat_cnt3;
`endif

    int tests  = 0;
    int failed = 0;
    logic [31:0] exp_q[$];

    assign vbus   = {data[3], data[2], data[1], data[0]};
    assign v3_bus = {32'h32, 32'h31, 32'h30};

    msg_send_arbiter #(.NUM_REQ(4), .WIDTH(32)) dut (
        .CLK          (clk),
        .nRST         (rst),
        .req_pend     (pend),
        .req_enq__ENA (ena),
        .req_enq_v    (vbus),
        .req_enq_last (last),
        .req_enq__RDY (rdy),
        .out_enq__ENA (out_ena),
        .out_enq_v    (out_v),
        .out_enq_last (out_last),
        .out_enq__RDY (out_rdy),
        .busy         (busy),
        .owner        (owner)
`ifdef MSG_SEND_ARB_STATS_EN
        ,
        .msg_count    (msg_cnt),
        .beat_count   (beat_cnt)
`endif
    );

    msg_send_arbiter #(.NUM_REQ(3), .WIDTH(32)) dut3 (
        .CLK          (clk),
        .nRST         (rst),
        .req_pend     (p3),
        .req_enq__ENA (e3),
        .req_enq_v    (v3_bus),
        .req_enq_last (l3),
        .req_enq__RDY (rdy3),
        .out_enq__ENA (ena3_o),
        .out_enq_v    (v3_o),
        .out_enq_last (last3_o),
        .out_enq__RDY (1'b1),
        .busy         (busy3),
        .owner        (owner3)
`ifdef MSG_SEND_ARB_STATS_EN
        ,
        .msg_count    (msg_cnt3),
        .beat_count   (beat_cnt3)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every beat the sink accepts must be the next expected payload.
    task automatic sb_sample(input string tag);
        if (out_ena === 1'b1) begin
            if (exp_q.size() == 0)
                chk({tag, "_sb_extra_beat"}, 64'(exp_q.size()), 64'd1);
            else
                chk({tag, "_sb_v"}, 64'(out_v), 64'(exp_q.pop_front()));
        end
    endtask

    // Driver: apply one cycle, check combinational outputs before the edge and state after it.
    task automatic cyc(input string tag, input logic [3:0] p, input logic [3:0] e,
                       input logic [3:0] l, input logic ordy, input logic [3:0] xrdy,
                       input logic xena, input logic xlast, input logic [1:0] xown,
                       input logic xbusy);
        @(negedge clk);
        pend = p; ena = e; last = l; out_rdy = ordy;
        #1;
        chk({tag, "_rdy"},  64'(rdy),      64'(xrdy));
        chk({tag, "_ena"},  64'(out_ena),  64'(xena));
        chk({tag, "_last"}, 64'(out_last), 64'(xlast));
        sb_sample(tag);
        @(posedge clk);
        #1;
        chk({tag, "_owner"}, 64'(owner), 64'(xown));
        chk({tag, "_busy"},  64'(busy),  64'(xbusy));
    endtask

    task automatic cyc3(input string tag, input logic [2:0] p, input logic [2:0] xrdy,
                        input logic [1:0] xown, input logic [31:0] xv);
        @(negedge clk);
        p3 = p; e3 = p; l3 = 3'b111;
        #1;
        chk({tag, "_rdy"}, 64'(rdy3), 64'(xrdy));
        chk({tag, "_v"},   64'(v3_o), 64'(xv));
        @(posedge clk);
        #1;
        chk({tag, "_owner"}, 64'(owner3), 64'(xown));
        chk({tag, "_busy"},  64'(busy3),  64'd0);
    endtask

    typedef struct {
        logic [3:0]  pend;
        logic [3:0]  ena;
        logic [3:0]  last;
        logic        ordy;
        logic [3:0]  exp_rdy;
        logic        exp_ena;
        logic [31:0] exp_v;
        logic        exp_last;
        logic [1:0]  exp_owner;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{4'hF, 4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 32'hD0, 1'b1, 2'd0, 1'b0};
        vecs[1]  = '{4'hF, 4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 32'hD1, 1'b1, 2'd1, 1'b0};
        vecs[2]  = '{4'hF, 4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 32'hD2, 1'b1, 2'd2, 1'b0};
        vecs[3]  = '{4'hF, 4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 32'hD3, 1'b1, 2'd3, 1'b0};
        vecs[4]  = '{4'hF, 4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 32'hD0, 1'b1, 2'd0, 1'b0};
        vecs[5]  = '{4'hF, 4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 32'hD1, 1'b1, 2'd1, 1'b0};
        vecs[6]  = '{4'hF, 4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 32'hD2, 1'b1, 2'd2, 1'b0};
        vecs[7]  = '{4'hF, 4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 32'hD3, 1'b1, 2'd3, 1'b0};
        vecs[8]  = '{4'hA, 4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 32'hD1, 1'b1, 2'd1, 1'b0};
        vecs[9]  = '{4'hA, 4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 32'hD3, 1'b1, 2'd3, 1'b0};
        vecs[10] = '{4'h0, 4'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 32'h0,  1'b0, 2'd3, 1'b0};

        rst = 1'b1; pend = '0; ena = '0; last = '0; out_rdy = 1'b1;
        p3 = '0; e3 = '0; l3 = '0;
        for (int i = 0; i < 4; i++) data[i] = 32'hD0 + 32'(i);

        // Reset held three cycles with every requester pending
        for (int i = 0; i < 3; i++)
            cyc("reset", 4'hF, 4'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
        rst = 1'b0;

        // Single-beat fairness, pend drop, idle
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].exp_ena) exp_q.push_back(vecs[i].exp_v);
            cyc($sformatf("vec%0d", i), vecs[i].pend, vecs[i].ena, vecs[i].last, vecs[i].ordy,
                vecs[i].exp_rdy, vecs[i].exp_ena, vecs[i].exp_last, vecs[i].exp_owner,
                vecs[i].exp_busy);
`ifdef MSG_SEND_ARB_STATS_EN
            if (i == 7) begin
                for (int r = 0; r < 4; r++)
                    chk($sformatf("msg_count%0d", r), 64'(msg_cnt[r*16 +: 16]), 64'd2);
                chk("beat_count", 64'(beat_cnt), 64'd8);
            end
`endif
        end

        // Atomicity: req0 sends A0,A1,A2 while req1 waits
        data[0] = 32'hA0; exp_q.push_back(32'hA0);
        cyc("atom0", 4'b0011, 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b1);
        data[0] = 32'hA1; exp_q.push_back(32'hA1);
        cyc("atom1", 4'b0010, 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b1);
        data[0] = 32'hA2; exp_q.push_back(32'hA2);
        cyc("atom2", 4'b0010, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0);
        data[1] = 32'hB0; exp_q.push_back(32'hB0);
        cyc("atom3", 4'b0010, 4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b0);

        // Backpressure mid-message of req2
        data[2] = 32'hC0; exp_q.push_back(32'hC0);
        cyc("bp_start", 4'b0100, 4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b0, 2'd2, 1'b1);
        for (int i = 0; i < 5; i++)
            cyc("bp_stall", 4'b1011, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b1);
        data[2] = 32'hC1; exp_q.push_back(32'hC1);
        cyc("bp_c1", 4'b1011, 4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b0, 2'd2, 1'b1);
        data[2] = 32'hC2; exp_q.push_back(32'hC2);
        cyc("bp_c2", 4'b1011, 4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0);

        // Protocol violation: req3 strobes without ready; nothing may change
        cyc("viol", 4'b0001, 4'b1000, 4'b1000, 1'b1, 4'b0001, 1'b0, 1'b0, 2'd2, 1'b0);
        exp_q.push_back(32'hD3);
        cyc("viol_after", 4'b1001, 4'b1001, 4'b1001, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 1'b0);

        // Reset while locked on owner 1
        data[1] = 32'hE0; exp_q.push_back(32'hE0);
        cyc("rl_lock", 4'b0010, 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b0, 2'd1, 1'b1);
        rst = 1'b1;
        cyc("rl_reset", 4'hF, 4'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
        rst = 1'b0;
        data[0] = 32'hF0; exp_q.push_back(32'hF0);
        cyc("rl_after", 4'hF, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0);

        chk("sb_drain", 64'(exp_q.size()), 64'd0);

        // Wrap with NUM_REQ=3
        cyc3("w3_a", 3'b010, 3'b010, 2'd1, 32'h31);
        cyc3("w3_b", 3'b011, 3'b001, 2'd0, 32'h30);
        cyc3("w3_c", 3'b011, 3'b010, 2'd1, 32'h31);
        cyc3("w3_d", 3'b100, 3'b100, 2'd2, 32'h32);
        cyc3("w3_e", 3'b111, 3'b001, 2'd0, 32'h30);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
